// File: rtl/syzygy_dds_mem_multi.sv
// Multi-channel BRAM waveform playback. Each channel has a fractional phase accumulator
// that reads two packed samples per 32-bit word; one IDLE/RUN/DONE controller keeps channels coherent.

module syzygy_dds_mem_multi_ch #(
  parameter int AW         = 21,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic                  oneshot,
  input  logic [AW:0]           lim,
  input  logic [AW-1:0]         end_acc,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [AW-1:0]         acc,
  output logic                  ended,
  output logic                  hit
);
  logic [AW-1:0] acc_q, acc_d;
  logic          ended_q, ended_d;
  logic [AW:0]   nxt, wrap;

  always_comb begin
    nxt     = {1'b0, acc_q} + {{(AW+1-RATE_WIDTH){1'b0}}, rate};
    wrap    = nxt - lim;
    hit     = oneshot && !ended_q && (nxt >= lim);
    acc_d   = acc_q;
    ended_d = ended_q;
    if (clr) begin
      acc_d   = '0;
      ended_d = 1'b0;
    end else if (step && !ended_q) begin
      if (nxt < lim)        acc_d = nxt[AW-1:0];
      else if (oneshot) begin
        acc_d   = end_acc;
        ended_d = 1'b1;
      end
      // a rate larger than the loop length cannot wrap cleanly; restart the table
      else if (wrap >= lim) acc_d = '0;
      else                  acc_d = wrap[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      ended_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ended_q <= ended_d;
    end
  end

  assign acc   = acc_q;
  assign ended = ended_q;
endmodule

module syzygy_dds_mem_multi #(
  parameter int                    NUM_CH        = 2,
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter int                    FRAC_BITS     = 8,
  parameter int                    RATE_WIDTH    = 16,
  parameter int                    MEM_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE    = 12'h800
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           mode,
  input  logic [MEM_ADDR_BITS:0]         length,
  input  logic [NUM_CH*RATE_WIDTH-1:0]   rate,
  output logic [NUM_CH*32-1:0]           mem_addr,
  input  logic [NUM_CH*32-1:0]           mem_data,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data,
  output logic                           data_valid,
  output logic                           busy,
  output logic                           done
);
  localparam int AW = MEM_ADDR_BITS + 1 + FRAC_BITS;
  localparam int LW = MEM_ADDR_BITS + 2;
  localparam int VS = MEM_LATENCY + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                                state_q, state_d;
  logic                                  mode_q, mode_d;
  logic [LW-1:0]                         len_q, len_d, len_eff, len_m1;
  logic [AW:0]                           lim;
  logic [AW-1:0]                         end_acc;
  logic [NUM_CH-1:0]                     ended, hit;
  logic [NUM_CH-1:0][AW-1:0]             acc;
  logic                                  clr, step;
  logic [VS-1:0]                         vld_pipe_q, vld_pipe_d;
  logic [NUM_CH-1:0][MEM_LATENCY-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic                                  unused_bits;

  always_comb begin
    if (length == '0)                             len_eff = LW'(1) << (LW-1);
    else if (length < (MEM_ADDR_BITS+1)'(2))      len_eff = LW'(2);
    else                                          len_eff = {1'b0, length};
  end

  assign lim     = {len_q, {FRAC_BITS{1'b0}}};
  assign len_m1  = len_q - LW'(1);
  assign end_acc = {len_m1[LW-2:0], {FRAC_BITS{1'b0}}};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    if (start) begin
      state_d = S_RUN;
      mode_d  = mode;
      len_d   = len_eff;
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (state_q == S_RUN && mode_q && (&(ended | hit))) begin
      state_d = S_DONE;
    end
  end

  // accumulators are zero whenever idle and restart from zero on every start
  assign clr  = start || (state_d == S_IDLE);
  assign step = (state_q == S_RUN) && !clr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    syzygy_dds_mem_multi_ch #(
      .AW         (AW),
      .RATE_WIDTH (RATE_WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .step    (step),
      .oneshot (mode_q),
      .lim     (lim),
      .end_acc (end_acc),
      .rate    (rate[c*RATE_WIDTH +: RATE_WIDTH]),
      .acc     (acc[c]),
      .ended   (ended[c]),
      .hit     (hit[c])
    );
    assign mem_addr[c*32 +: 32] = 32'({acc[c][AW-1:FRAC_BITS+1], 2'b00});
  end

  always_comb begin
    vld_pipe_d[0] = (state_q != S_IDLE);
    for (int k = 1; k < VS; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    for (int c = 0; c < NUM_CH; c++) begin
      sel_d[c][0] = acc[c][FRAC_BITS];
      for (int k = 1; k < MEM_LATENCY; k++) sel_d[c][k] = sel_q[c][k-1];
      data_d[c] = IDLE_VALUE;
      if (vld_pipe_q[VS-2])
        data_d[c] = sel_q[c][MEM_LATENCY-1] ? mem_data[c*32+16 +: DATA_WIDTH]
                                            : mem_data[c*32 +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      len_q      <= LW'(2);
      vld_pipe_q <= '0;
      sel_q      <= '0;
      data_q     <= {NUM_CH{IDLE_VALUE}};
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      vld_pipe_q <= vld_pipe_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = vld_pipe_q[VS-1];
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign unused_bits = ^{mem_data, acc, len_m1};
endmodule

// File: tb/tb_syzygy_dds_mem_multi.sv
// Scoreboard bench: a sample-index reference model predicts every cycle's outputs,
// a negedge monitor compares them against the DUT.

module tb_syzygy_dds_mem_multi;
  localparam int NCH = 2, DW = 12, MAB = 12, RW = 16;

  logic                clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [MAB:0]        length = '0;
  logic [NCH*RW-1:0]   rate = '0;
  logic [NCH*32-1:0]   mem_addr, mem_data;
  logic [NCH*DW-1:0]   data;
  logic                data_valid, busy, done;
  logic [31:0]         mem [NCH][4096];
  int                  checks = 0, errors = 0;

  syzygy_dds_mem_multi dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .length(length), .rate(rate), .mem_addr(mem_addr), .mem_data(mem_data),
    .data(data), .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // one-cycle-latency BRAM
  always @(posedge clk)
    for (int c = 0; c < NCH; c++) mem_data[c*32 +: 32] <= mem[c][mem_addr[c*32+2 +: MAB]];

  typedef struct { int due; logic vld; logic [NCH*DW-1:0] d; } dexp_t;
  typedef struct { int due; logic bsy; logic dn; logic [NCH*32-1:0] a; } cexp_t;
  dexp_t dq[$];
  cexp_t cq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] samp(input int c, input int unsigned idx);
    logic [31:0] w;
    w = mem[c][idx/2];
    return (idx % 2) ? w[16 +: DW] : w[0 +: DW];
  endfunction

  // reference model: st 0=idle 1=run 2=done, acc in 1/256 sample units
  int          cyc = 0;
  int          m_st = 0;
  bit          m_mode = 0;
  int unsigned m_len = 2;
  int unsigned m_acc [NCH];
  bit          m_end [NCH];

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_st = 0;
        for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_end[c] = 0; end
        dq.delete();
        cq.delete();
      end else begin
        int unsigned lim;
        bit all;
        dexp_t de;
        cexp_t ce;
        cyc++;
        if (start) begin
          m_st = 1; m_mode = mode;
          m_len = (length == 0) ? 8192 : ((length < 2) ? 2 : int'(length));
          for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_end[c] = 0; end
        end else if (stop) begin
          m_st = 0;
          for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_end[c] = 0; end
        end else if (m_st == 1) begin
          lim = m_len * 256;
          all = 1;
          for (int c = 0; c < NCH; c++) begin
            if (!m_end[c]) begin
              int unsigned n;
              n = m_acc[c] + rate[c*RW +: RW];
              if (n < lim) m_acc[c] = n;
              else if (m_mode) begin m_acc[c] = (m_len - 1) * 256; m_end[c] = 1; end
              else begin n = n - lim; m_acc[c] = (n >= lim) ? 0 : n; end
            end
            all &= m_end[c];
          end
          if (m_mode && all) m_st = 2;
        end
        ce.due = cyc; ce.bsy = (m_st == 1); ce.dn = (m_st == 2);
        de.due = cyc + 2; de.vld = (m_st != 0);
        for (int c = 0; c < NCH; c++) begin
          ce.a[c*32 +: 32] = (m_acc[c] >> 9) << 2;
          de.d[c*DW +: DW] = (m_st != 0) ? samp(c, m_acc[c] >> 8) : 12'h800;
        end
        cq.push_back(ce);
        dq.push_back(de);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (cq.size() > 0 && cq[0].due <= cyc) begin
        cexp_t e;
        e = cq.pop_front();
        chk("busy", 64'(busy), 64'(e.bsy));
        chk("done", 64'(done), 64'(e.dn));
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
      end
      while (dq.size() > 0 && dq[0].due <= cyc) begin
        dexp_t e;
        e = dq.pop_front();
        chk("data_valid", 64'(data_valid), 64'(e.vld));
        chk("data", 64'(data), 64'(e.d));
      end
    end
  end

  task automatic tk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic m, input logic [MAB:0] len);
    mode = m; length = len; start = 1'b1; tk(1); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tk(1); stop = 1'b0;
  endtask

  task automatic set_rate(input logic [RW-1:0] r0, input logic [RW-1:0] r1);
    rate = {r1, r0};
  endtask

  task automatic reset_checks(input string tag);
    logic [NCH*DW-1:0] idle_exp;
    idle_exp = {NCH{12'h800}};
    chk({tag, "_data"}, 64'(data), 64'(idle_exp));
    chk({tag, "_valid"}, 64'(data_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
  endtask

  initial begin : stim
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 4096; i++) mem[c][i] = $urandom;
    tk(3);
    reset_checks("reset");
    @(posedge clk); #2 reset_n = 1'b1;
    tk(2);
    // integer-rate loop, then fractional-rate loop
    set_rate(16'h0100, 16'h0080); do_start(1'b0, 13'd10); tk(30);
    set_rate(16'h0180, 16'h0100); do_start(1'b0, 13'd10); tk(30);
    // one-shot, hold in DONE, replay
    set_rate(16'h0100, 16'h0100); do_start(1'b1, 13'd4); tk(10);
    do_start(1'b1, 13'd4); tk(10);
    // stop mid-run
    do_start(1'b0, 13'd20); tk(5); do_stop(); tk(5);
    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; tk(1); start = 1'b0; stop = 1'b0; tk(5);
    do_stop(); tk(3);
    // async reset between edges
    do_start(1'b0, 13'd10); tk(7);
    #1 reset_n = 1'b0;
    #1 reset_checks("async_reset");
    tk(2);
    #1 reset_n = 1'b1;
    tk(2);
    // full-length table, 1x and 2x rates
    set_rate(16'h0100, 16'h0200); do_start(1'b0, 13'd0); tk(8300);
    do_stop(); tk(3);
    // randomized control and rates
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) begin
        for (int c = 0; c < NCH; c++)
          rate[c*RW +: RW] = ($urandom_range(0, 9) == 0) ? RW'($urandom) : RW'($urandom_range(0, 16'h0600));
      end
      if (r < 3) begin
        mode = 1'($urandom);
        length = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(0, 1)) : 13'($urandom_range(2, 40));
      end
      start = (r < 3);
      stop  = (r >= 3 && r < 5) || (r < 1);
      tk(1);
    end
    start = 1'b0; stop = 1'b0;
    tk(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
